icache_fill: RTL
================

# icache_fill

Instruction-cache line-fill engine: the memory-side counterpart of the instruction cache. On a cache miss it reads one aligned block from the byte-wide RAM port, assembling it little-endian. It then delivers the block to the cache through a one-cycle write strobe with block address and data. It sits between the instruction cache and the RAM port; this spec defines no arbitration, and the block owns the RAM port while busy.

## Interface
Parameters:
- BLK_BYTES, 64: bytes per cache block. Power of two, ≥ 2.
- OFF_BITS, log2(BLK_BYTES) = 6: block-offset width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_in  in  1  reset, synchronous, active-low
- miss  in  1  cache miss for if_ain, combinational from the cache
- if_ain  in  32  current fetch address
- flush  in  1  abort the in-flight fill (e.g. branch redirect)
- ram_din  in  8  RAM read data; carries the byte at the ram_a presented one cycle earlier
- ram_a  out  32  RAM byte address, registered
- ram_wr  out  1  RAM write enable; constant 0
- busy  out  1  high in READ and DONE
- fill_en  out  1  one-cycle strobe to the cache write port
- fill_addr  out  32  block base address; valid while fill_en is high
- fill_data  out  8*BLK_BYTES  assembled block; byte i is at [8i+7:8i]

## Operation
- State machine: IDLE, READ, DONE. Internal registers:
  - base (32)
  - issue counter icnt (OFF_BITS+1)
  - receive counter rcnt (OFF_BITS+1)
  - data buffer (8*BLK_BYTES)
- Reset (rst_in = 0 at an edge): state = IDLE; ram_a = 0; ram_wr = 0; busy = 0; fill_en = 0; fill_addr = 0; fill_data = 0; icnt = rcnt = 0.
- IDLE:
  - If miss = 1 and flush = 0:
    - base <= {if_ain[31:OFF_BITS], OFF_BITS'b0}
    - ram_a <= {if_ain[31:OFF_BITS], OFF_BITS'b0}
    - icnt <= 1, rcnt <= 0
    - go to READ
  - Otherwise stay in IDLE.
- READ, each cycle:
  - Issue: if icnt < BLK_BYTES, then ram_a <= base + icnt and icnt++. Otherwise ram_a holds at base + BLK_BYTES − 1.
  - Capture: buffer[rcnt] <= ram_din and rcnt++.
  - When the capture is byte BLK_BYTES−1 (rcnt = BLK_BYTES−1 this cycle), go to DONE.
- DONE (exactly one cycle):
  - fill_en = 1, fill_addr = base, fill_data = full buffer.
  - Then go to IDLE.
- fill_data and fill_addr hold their values after DONE until the next capture or fill. Only fill_en qualifies them.
- ram_a holds its last value in IDLE and DONE.
- flush:
  - In READ: go to IDLE next edge, no fill_en. A partially written buffer is allowed.
  - In IDLE together with miss: flush wins, stay in IDLE.
  - In DONE: ignored. The fill completes, because the data is correct for fill_addr.
- miss while in READ or DONE: ignored. No queueing; the cache re-raises miss if it still misses.
- Address arithmetic is 32-bit. Base is aligned, so base + BLK_BYTES − 1 never wraps. Block 0xFFFFFFC0 fetches 0xFFFFFFC0..0xFFFFFFFF.

## Timing
- Cycle 0 is the cycle in which IDLE samples miss = 1.
  - ram_a = base in cycle 1.
  - ram_a = base + k in cycle k+1, for k = 0..BLK_BYTES−1.
  - Byte k is captured in cycle k+2.
  - DONE and fill_en = 1 occur in cycle BLK_BYTES+2 (66 for the default).
- The cache writes at the end of the fill_en cycle. The engine is in IDLE in cycle BLK_BYTES+3 and sees the updated miss there, so there is no double fill of the same block.
- Minimum gap between two fills: BLK_BYTES+3 cycles.
- busy is registered: high from cycle 1 through cycle BLK_BYTES+2.

## Test plan
- Reset: hold rst_in = 0 for 2 cycles with miss = 1 -> all outputs 0, state IDLE. Release -> READ entered on the next edge.
- Single fill, default BLK_BYTES, RAM model with byte[a] = a[7:0], miss with if_ain = 0x0000_1234:
  - ram_a steps 0x1200..0x123F in cycles 1..64.
  - fill_en is high only in cycle 66, with fill_addr = 0x0000_1200.
  - fill_data byte i = 0x00 + i.
- Miss held high after the fill (cache model slow to update) -> exactly one fill_en per fill. A new fill starts only from IDLE.
- Flush in cycle 20 of a fill -> no fill_en; IDLE in cycle 21. A following miss at 0x80 -> clean fill, fill_data byte i = 0x80 + i.
- Flush asserted in the DONE cycle -> fill_en still 1 with the correct data. Flush together with miss in IDLE -> stays in IDLE, ram_a unchanged.
- Top block, if_ain = 0xFFFF_FFF8 -> ram_a runs 0xFFFF_FFC0..0xFFFF_FFFF with no wrap to 0; fill_addr = 0xFFFF_FFC0.

Source files
------------

// File: rtl/icache_fill.sv
// rtl/icache_fill.sv - instruction-cache line-fill engine, byte-wide RAM to block write strobe
module icache_fill #(
  parameter int BLK_BYTES = 64,
  parameter int OFF_BITS  = $clog2(BLK_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   miss,
  input  logic [31:0]            if_ain,
  input  logic                   flush,
  input  logic [7:0]             ram_din,
  output logic [31:0]            ram_a,
  output logic                   ram_wr,
  output logic                   busy,
  output logic                   fill_en,
  output logic [31:0]            fill_addr,
  output logic [8*BLK_BYTES-1:0] fill_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  localparam logic [OFF_BITS:0] BLK_CNT  = (OFF_BITS+1)'(BLK_BYTES);
  localparam logic [31:0]       OFF_MASK = 32'(BLK_BYTES - 1);

  state_t                 state_q, state_d;
  logic [31:0]            base_q, base_d;
  logic [31:0]            ram_a_q, ram_a_d;
  logic [OFF_BITS:0]      icnt_q, icnt_d;
  logic [OFF_BITS:0]      rcnt_q, rcnt_d;
  logic                   cap_q, cap_d;
  logic [8*BLK_BYTES-1:0] buf_q, buf_d;
  logic                   busy_q, busy_d;
  logic                   fill_en_q, fill_en_d;
  logic [31:0]            fill_addr_q, fill_addr_d;

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      ram_a_q     <= '0;
      icnt_q      <= '0;
      rcnt_q      <= '0;
      cap_q       <= 1'b0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      fill_en_q   <= 1'b0;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      ram_a_q     <= ram_a_d;
      icnt_q      <= icnt_d;
      rcnt_q      <= rcnt_d;
      cap_q       <= cap_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
      fill_en_q   <= fill_en_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    ram_a_d     = ram_a_q;
    icnt_d      = icnt_q;
    rcnt_d      = rcnt_q;
    cap_d       = cap_q;
    buf_d       = buf_q;
    busy_d      = 1'b0;
    fill_en_d   = 1'b0;
    fill_addr_d = fill_addr_q;
    case (state_q)
      S_IDLE: begin
        if (miss && !flush) begin
          base_d  = if_ain & ~OFF_MASK;
          ram_a_d = if_ain & ~OFF_MASK;
          icnt_d  = (OFF_BITS+1)'(1);
          rcnt_d  = '0;
          cap_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        busy_d = 1'b1;
        if (icnt_q < BLK_CNT) begin
          ram_a_d = base_q + 32'(icnt_q);
          icnt_d  = icnt_q + 1'b1;
        end
        // RAM data lags the address by a cycle, so capture starts one cycle after entry
        cap_d = 1'b1;
        if (cap_q) begin
          buf_d[8*rcnt_q[OFF_BITS-1:0] +: 8] = ram_din;
          rcnt_d = rcnt_q + 1'b1;
        end
        if (flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cap_q && rcnt_q == BLK_CNT - 1'b1) begin
          fill_en_d   = 1'b1;
          fill_addr_d = base_q;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_a     = ram_a_q;
  assign ram_wr    = 1'b0;
  assign busy      = busy_q;
  assign fill_en   = fill_en_q;
  assign fill_addr = fill_addr_q;
  assign fill_data = buf_q;

endmodule
